// File: rtl/micro_pipe_controller_if.sv
// Handshake bundle between the microsequencer and the stage-3/stage-4 registers,
// control store and memory port.
interface micro_pipe_controller_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              start;
    logic [ADDR_W-1:0] T3;
    logic [1:0]        COND3;
    logic [1:0]        M3;
    logic              zero_flag;
    logic              mem_ack;
    logic [ADDR_W-1:0] mpc;
    logic              v3;
    logic              stall;
    logic              flush;
    logic              mem_req;
    logic              mem_we;
    logic              halted;
    logic              err;

    modport master (
        input  start, T3, COND3, M3, zero_flag, mem_ack,
        output mpc, v3, stall, flush, mem_req, mem_we, halted, err
    );

    modport slave (
        output start, T3, COND3, M3, zero_flag, mem_ack,
        input  mpc, v3, stall, flush, mem_req, mem_we, halted, err
    );
endinterface

// File: rtl/micro_pipe_controller.sv
// Microsequencer: drives the control-store address, tracks stage-3 validity and
// turns the stage-3 condition/memory fields into stall, flush and halt.
module micro_pipe_controller #(
    parameter int unsigned       ADDR_W     = 7,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    micro_pipe_controller_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, HALT} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] mpc_q;
    logic              v3_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              err_q;
    logic              mem_done_q;

    logic              decode;
    logic              mem_op;
    logic              taken;
    logic              halt_op;
    logic              rsvd_op;

    // Stage-3 decode. mem_done_q masks the memory field while the held
    // microinstruction gets its second (branch) decode after the ack.
    always_comb begin
        decode  = (state == RUN) && v3_q;
        mem_op  = decode && !mem_done_q && ((bus.M3 == 2'b01) || (bus.M3 == 2'b10));
        taken   = decode && !mem_op &&
                  ((bus.COND3 == 2'b01) || ((bus.COND3 == 2'b10) && bus.zero_flag));
        halt_op = decode && !mem_op && (bus.COND3 == 2'b11);
        rsvd_op = decode && (bus.M3 == 2'b11);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (bus.start) state_next = RUN;
            RUN: begin
                if (mem_op)       state_next = MEM_WAIT;
                else if (halt_op) state_next = HALT;
            end
            MEM_WAIT: if (bus.mem_ack) state_next = RUN;
            HALT:     if (bus.start) state_next = RUN;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.stall  = mem_op || ((state == MEM_WAIT) && !bus.mem_ack);
        bus.flush  = taken;
        bus.halted = (state == HALT);
    end

    // Fetch stage: MPC, stage-3 valid and the registered memory handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            mpc_q      <= RESET_ADDR;
            v3_q       <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            err_q      <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            if (rsvd_op) err_q <= 1'b1;
            mem_done_q <= (state == MEM_WAIT) && bus.mem_ack;
            case (state)
                IDLE: begin
                    if (bus.start) mpc_q <= RESET_ADDR;
                end
                RUN: begin
                    if (mem_op) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= bus.M3[1];
                    end else if (taken) begin
                        mpc_q <= bus.T3;
                        v3_q  <= 1'b0;
                    end else if (halt_op) begin
                        v3_q <= 1'b0;
                    end else begin
                        mpc_q <= mpc_q + ADDR_W'(1);
                        v3_q  <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                HALT: begin
                    if (bus.start) mpc_q <= RESET_ADDR;
                end
                default: ;
            endcase
        end
    end

    assign bus.mpc     = mpc_q;
    assign bus.v3      = v3_q;
    assign bus.mem_req = mem_req_q;
    assign bus.mem_we  = mem_we_q;
    assign bus.err     = err_q;
endmodule
